instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Streaming RV64I instruction encoder and instruction-memory loader, the inverse of the decode stage.
//  It accepts decoded fields (format, opcode, registers, functs, 32-bit signed immediate) over a valid/ready stream.
//  It packs the fields into 32-bit instruction words and writes them to consecutive imem words starting at BASE_ADDR.
//  Used by the boot/test loader to fill imem before the core leaves reset.
// PARAMETERS
//  ADDR_W     10  imem word-address width; capacity DEPTH = 2**ADDR_W words
//  BASE_ADDR  0   first imem word address written after start
// PORTS
//  clk         in   1       clock
//  reset       in   1       asynchronous, active-high
//  start       in   1       begin load session (honoured only in IDLE/DONE)
//  in_valid    in   1       field bundle valid
//  in_ready    out  1       encoder can accept
//  in_fmt      in   3       0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//  in_opcode   in   7       opcode, passed through unchecked
//  in_rd/in_rs1/in_rs2  in  5 each  register indices
//  in_funct3   in   3       funct3
//  in_funct7   in   7       funct7 (R only)
//  in_imm      in   32      signed immediate, byte offset for B/J, full value for U
//  in_last     in   1       final bundle of session
//  imem_we     out  1       one-cycle write strobe
//  imem_addr   out  ADDR_W  write word address
//  imem_wdata  out  32      encoded instruction
//  busy        out  1       state != IDLE && state != DONE
//  done        out  1       session finished, held until next start
//  err         out  1       sticky: at least one bundle dropped
//  err_code    out  2       first error: 0 FMT, 1 RANGE, 2 ALIGN, 3 OVERFLOW
//  count       out  ADDR_W+1  words written this session
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0, including in_ready, imem_*, done, err, count. Any pending write is discarded.
//  FSM: IDLE --start--> LOAD. LOAD --in_last accepted--> FLUSH. FLUSH --(1 cycle)--> DONE. DONE --start--> LOAD.
//  start in LOAD/FLUSH is ignored.
//  On entering LOAD: count=0, err=0, err_code=0, done=0, write pointer=BASE_ADDR.
//  in_ready = (state==LOAD). A transfer occurs when in_valid && in_ready.
//  Latency: a transfer at cycle N gives imem_we=1 at N+1, with addr and wdata registered. Throughput is 1 per cycle.
//  Encodings:
//   R  {f7,rs2,rs1,f3,rd,op}
//   I  {imm[11:0],rs1,f3,rd,op}
//   S  {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   B  {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
//   U  {imm[31:12],rd,op}
//   J  {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//  Checks, applied in priority order FMT > ALIGN > RANGE:
//   FMT: in_fmt 6/7
//   ALIGN: B/J with imm[0]=1; U with imm[11:0]!=0
//   RANGE: I/S outside [-2048,2047]; B outside [-4096,4094]; J outside [-2^20,2^20-2]
//  A failing bundle is dropped: no imem_we, count and pointer unchanged. err is set.
//  err_code latches only the first error of the session.
//  Overflow: a transfer when count==DEPTH is dropped with OVERFLOW. No wrap-around write ever occurs.
//  Pointer = BASE_ADDR+count, modulo 2**ADDR_W.
//  in_last on a dropped bundle still ends the session (LOAD->FLUSH).
//  done=1 two cycles after the in_last transfer. imem_we is never high in DONE.
//  count increments in the same cycle imem_we is asserted.
//  Reset mid-session returns to IDLE immediately. A write registered but not yet strobed is lost.
// TESTING
//  I: fmt1 op=0x13 rd1 rs1=0 f3=0 imm=5 -> next cycle imem_we=1, addr=0, wdata=0x00500093, count=1.
//  Back-to-back R then S (in_valid held):
//   add x3,x1,x2 -> 0x002081B3 at addr 0
//   sw x2,8(x1) -> 0x0020A423 at addr 1
//   then in_last -> done=1 two cycles after the last transfer.
//  B/J/U packing:
//   beq x1,x2,-4 -> 0xFE208EE3
//   jal x1,2048 -> 0x001000EF
//   lui x5,0x12345000 -> 0x123452B7
//  Errors:
//   I imm=2048 -> no write, err=1, err_code=1
//   later B imm=3 -> err_code stays 1, count unchanged
//  Overflow with ADDR_W=2: 5 transfers -> 4 writes to addr 0..3, then err_code=3, count=4.
//  Reset asserted the cycle after a transfer -> imem_we stays 0, all outputs 0, state IDLE.
//  start in LOAD -> ignored.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream, imem write port and session status for the instruction encoder/loader.
// The slave modport is the encoder side; the master modport is the boot loader or bench side.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   count;

    modport master (
        output start, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err,
               err_code, count
    );

    modport slave (
        input  start, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err,
               err_code, count
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Streaming RV64I field-to-word encoder that writes packed instructions into consecutive imem words.
// Bad bundles are dropped and the first error cause of a session is latched.
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_encoder_loader_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [2:0] F_R = 3'd0;
    localparam logic [2:0] F_I = 3'd1;
    localparam logic [2:0] F_S = 3'd2;
    localparam logic [2:0] F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4;
    localparam logic [2:0] F_J = 3'd5;

    localparam logic [1:0] E_FMT   = 2'd0;
    localparam logic [1:0] E_RANGE = 2'd1;
    localparam logic [1:0] E_ALIGN = 2'd2;
    localparam logic [1:0] E_OVF   = 2'd3;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic [ADDR_W:0]   r_count;

    logic              w_xfer;
    logic              w_start;
    logic [31:0]       w_word;
    logic              w_drop;
    logic [1:0]        w_drop_code;
    logic              w_fmt_bad;
    logic              w_align_bad;
    logic              w_range_bad;
    logic              w_ovf;
    logic [ADDR_W-1:0] w_ptr;
    logic signed [31:0] w_simm;
    logic [31:0]       w_imm;

    assign w_imm   = bus.in_imm;
    assign w_simm  = signed'(bus.in_imm);
    assign w_xfer  = bus.in_valid && (r_state == S_LOAD);
    assign w_start = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // Count never exceeds DEPTH, so the low bits are the offset of the next free word.
    assign w_ptr   = BASE_C + r_count[ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_LOAD;
            S_LOAD:  if (w_xfer && bus.in_last) w_state_next = S_FLUSH;
            S_FLUSH: w_state_next = S_DONE;
            S_DONE:  if (w_start) w_state_next = S_LOAD;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_word = 32'd0;
        case (bus.in_fmt)
            F_R: w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            F_I: w_word = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            F_S: w_word = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0], bus.in_opcode};
            F_B: w_word = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           w_imm[4:1], w_imm[11], bus.in_opcode};
            F_U: w_word = {w_imm[31:12], bus.in_rd, bus.in_opcode};
            F_J: w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, bus.in_opcode};
            default: w_word = 32'd0;
        endcase
    end

    always_comb begin
        w_fmt_bad   = (bus.in_fmt > F_J);
        w_align_bad = (((bus.in_fmt == F_B) || (bus.in_fmt == F_J)) && w_imm[0])
                   || ((bus.in_fmt == F_U) && (w_imm[11:0] != 12'd0));
        w_range_bad = 1'b0;
        case (bus.in_fmt)
            F_I, F_S: w_range_bad = (w_simm < -32'sd2048)    || (w_simm > 32'sd2047);
            F_B:      w_range_bad = (w_simm < -32'sd4096)    || (w_simm > 32'sd4094);
            F_J:      w_range_bad = (w_simm < -32'sd1048576) || (w_simm > 32'sd1048574);
            default:  w_range_bad = 1'b0;
        endcase
        w_ovf = (r_count == DEPTH_C);

        w_drop      = 1'b1;
        w_drop_code = E_FMT;
        if (w_fmt_bad) begin
            w_drop_code = E_FMT;
        end else if (w_align_bad) begin
            w_drop_code = E_ALIGN;
        end else if (w_range_bad) begin
            w_drop_code = E_RANGE;
        end else if (w_ovf) begin
            w_drop_code = E_OVF;
        end else begin
            w_drop = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_count    <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= 2'd0;
                r_count    <= '0;
            end
            if (r_state == S_FLUSH) begin
                r_done <= 1'b1;
            end
            if (w_xfer) begin
                if (w_drop) begin
                    // Only the first failure of the session is reported.
                    if (!r_err) r_err_code <= w_drop_code;
                    r_err <= 1'b1;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= w_ptr;
                    r_wdata <= w_word;
                    r_count <= r_count + (ADDR_W+1)'(1);
                end
            end
        end
    end

    assign bus.in_ready   = (r_state == S_LOAD);
    assign bus.busy       = (r_state == S_LOAD) || (r_state == S_FLUSH);
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;
    assign bus.count      = r_count;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a 1024-word instance for encoding/error/reset cases
// and a 4-word instance for overflow.
module tb_instr_encoder_loader;
    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    instr_encoder_loader_if #(.ADDR_W(10)) bus ();
    instr_encoder_loader_if #(.ADDR_W(2))  bus2 ();

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we)  $display("write  addr=%0d data=%08h count=%0d", bus.imem_addr, bus.imem_wdata, bus.count);
        if (bus2.imem_we) $display("write2 addr=%0d data=%08h count=%0d", bus2.imem_addr, bus2.imem_wdata, bus2.count);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.start = 0; bus.in_valid = 0; bus.in_fmt = 0; bus.in_opcode = 0; bus.in_rd = 0;
        bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_funct3 = 0; bus.in_funct7 = 0; bus.in_imm = 0; bus.in_last = 0;
        bus2.start = 0; bus2.in_valid = 0; bus2.in_fmt = 0; bus2.in_opcode = 0; bus2.in_rd = 0;
        bus2.in_rs1 = 0; bus2.in_rs2 = 0; bus2.in_funct3 = 0; bus2.in_funct7 = 0; bus2.in_imm = 0; bus2.in_last = 0;
    endtask

    task automatic set_b(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm, input logic last);
        bus.in_valid = 1; bus.in_fmt = fmt; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1;
        bus.in_rs2 = rs2; bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm; bus.in_last = last;
    endtask

    task automatic start_session;
        bus.start = 1;
        tick;
        bus.start = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        clear_inputs;
        repeat (2) tick;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_ready got %0b want 0", bus.in_ready); else n_pass++;
        n_total++; if (bus.imem_we !== 1'b0 || bus.imem_addr !== 10'd0 || bus.imem_wdata !== 32'd0)
            $display("FAIL reset_imem got we=%0b addr=%0d data=%08h want 0/0/0", bus.imem_we, bus.imem_addr, bus.imem_wdata);
        else n_pass++;
        n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.err_code !== 2'd0 || bus.count !== 11'd0)
            $display("FAIL reset_status got busy=%0b done=%0b err=%0b code=%0d count=%0d want all 0",
                     bus.busy, bus.done, bus.err, bus.err_code, bus.count);
        else n_pass++;
        reset = 0;
        tick;
        n_total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL idle_after_reset got busy=%0b ready=%0b want 0/0", bus.busy, bus.in_ready); else n_pass++;
    endtask

    task automatic test_i_type;
        start_session;
        n_total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) $display("FAIL load_entry got ready=%0b busy=%0b want 1/1", bus.in_ready, bus.busy); else n_pass++;
        set_b(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        tick;
        bus.in_valid = 0;
        n_total++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd0 || bus.imem_wdata !== 32'h00500093 || bus.count !== 11'd1)
            $display("FAIL i_write got we=%0b addr=%0d data=%08h count=%0d want 1/0/00500093/1", bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.count);
        else n_pass++;
        tick;
        n_total++; if (bus.imem_we !== 1'b0) $display("FAIL i_strobe_width got %0b want 0", bus.imem_we); else n_pass++;
        set_b(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 1'b1);
        tick;
        bus.in_valid = 0;
        n_total++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd1 || bus.imem_wdata !== 32'h80000113 || bus.busy !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL i_min_imm got we=%0b addr=%0d data=%08h busy=%0b done=%0b want 1/1/80000113/1/0",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.busy, bus.done);
        else n_pass++;
        tick;
        n_total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.imem_we !== 1'b0 || bus.count !== 11'd2)
            $display("FAIL i_done got done=%0b busy=%0b we=%0b count=%0d want 1/0/0/2", bus.done, bus.busy, bus.imem_we, bus.count);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        start_session;
        n_total++; if (bus.count !== 11'd0 || bus.done !== 1'b0) $display("FAIL restart_clear got count=%0d done=%0b want 0/0", bus.count, bus.done); else n_pass++;
        set_b(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        tick;
        n_total++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd0 || bus.imem_wdata !== 32'h002081B3)
            $display("FAIL add_write got we=%0b addr=%0d data=%08h want 1/0/002081B3", bus.imem_we, bus.imem_addr, bus.imem_wdata);
        else n_pass++;
        set_b(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1);
        tick;
        bus.in_valid = 0;
        n_total++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd1 || bus.imem_wdata !== 32'h0020A423 || bus.count !== 11'd2)
            $display("FAIL sw_write got we=%0b addr=%0d data=%08h count=%0d want 1/1/0020A423/2", bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.count);
        else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL b2b_done_early got %0b want 0", bus.done); else n_pass++;
        tick;
        n_total++; if (bus.done !== 1'b1 || bus.imem_we !== 1'b0) $display("FAIL b2b_done got done=%0b we=%0b want 1/0", bus.done, bus.imem_we); else n_pass++;
    endtask

    task automatic test_bju;
        start_session;
        set_b(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0);
        tick;
        n_total++; if (bus.imem_we !== 1'b1 || bus.imem_wdata !== 32'hFE208EE3) $display("FAIL beq_word got we=%0b data=%08h want 1/FE208EE3", bus.imem_we, bus.imem_wdata); else n_pass++;
        set_b(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
        tick;
        n_total++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd1 || bus.imem_wdata !== 32'h001000EF)
            $display("FAIL jal_word got we=%0b addr=%0d data=%08h want 1/1/001000EF", bus.imem_we, bus.imem_addr, bus.imem_wdata);
        else n_pass++;
        set_b(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1);
        tick;
        bus.in_valid = 0;
        n_total++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd2 || bus.imem_wdata !== 32'h123452B7 || bus.count !== 11'd3)
            $display("FAIL lui_word got we=%0b addr=%0d data=%08h count=%0d want 1/2/123452B7/3", bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.count);
        else n_pass++;
        tick;
    endtask

    task automatic test_errors;
        start_session;
        n_total++; if (bus.err !== 1'b0 || bus.err_code !== 2'd0) $display("FAIL err_clear got err=%0b code=%0d want 0/0", bus.err, bus.err_code); else n_pass++;
        set_b(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
        tick;
        n_total++; if (bus.imem_we !== 1'b0 || bus.err !== 1'b1 || bus.err_code !== 2'd1 || bus.count !== 11'd0)
            $display("FAIL range_drop got we=%0b err=%0b code=%0d count=%0d want 0/1/1/0", bus.imem_we, bus.err, bus.err_code, bus.count);
        else n_pass++;
        set_b(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0);
        tick;
        n_total++; if (bus.imem_we !== 1'b0 || bus.err_code !== 2'd1 || bus.count !== 11'd0)
            $display("FAIL first_err_kept got we=%0b code=%0d count=%0d want 0/1/0", bus.imem_we, bus.err_code, bus.count);
        else n_pass++;
        set_b(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0);
        tick;
        n_total++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd0 || bus.imem_wdata !== 32'h00700113 || bus.count !== 11'd1)
            $display("FAIL ptr_after_drop got we=%0b addr=%0d data=%08h count=%0d want 1/0/00700113/1", bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.count);
        else n_pass++;
        set_b(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
        tick;
        bus.in_valid = 0;
        n_total++; if (bus.imem_we !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.count !== 11'd1)
            $display("FAIL fmt_last_drop got we=%0b busy=%0b ready=%0b count=%0d want 0/1/0/1", bus.imem_we, bus.busy, bus.in_ready, bus.count);
        else n_pass++;
        tick;
        n_total++; if (bus.done !== 1'b1) $display("FAIL dropped_last_done got %0b want 1", bus.done); else n_pass++;
    endtask

    task automatic test_start_ignored;
        start_session;
        set_b(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        tick;
        bus.in_valid = 0;
        bus.start = 1;
        tick;
        bus.start = 0;
        n_total++; if (bus.count !== 11'd1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b1)
            $display("FAIL start_in_load got count=%0d busy=%0b ready=%0b want 1/1/1", bus.count, bus.busy, bus.in_ready);
        else n_pass++;
        set_b(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8193, 1'b0);
        tick;
        n_total++; if (bus.err_code !== 2'd2 || bus.imem_we !== 1'b0) $display("FAIL align_prio got code=%0d we=%0b want 2/0", bus.err_code, bus.imem_we); else n_pass++;
        set_b(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 1'b1);
        tick;
        bus.in_valid = 0;
        bus.start = 1;
        tick;
        bus.start = 0;
        n_total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err_code !== 2'd2 || bus.count !== 11'd1)
            $display("FAIL start_in_flush got done=%0b busy=%0b code=%0d count=%0d want 1/0/2/1", bus.done, bus.busy, bus.err_code, bus.count);
        else n_pass++;
    endtask

    task automatic test_overflow;
        bus2.start = 1;
        tick;
        bus2.start = 0;
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1; bus2.in_fmt = 3'd1; bus2.in_opcode = 7'h13; bus2.in_rd = 5'd1;
            bus2.in_imm = 32'(i); bus2.in_last = (i == 4);
            tick;
            if (i < 4) begin
                n_total++; if (bus2.imem_we !== 1'b1 || bus2.imem_addr !== 2'(i) || bus2.count !== 3'(i + 1))
                    $display("FAIL ovf_write%0d got we=%0b addr=%0d count=%0d want 1/%0d/%0d", i, bus2.imem_we, bus2.imem_addr, bus2.count, i, i + 1);
                else n_pass++;
            end else begin
                n_total++; if (bus2.imem_we !== 1'b0 || bus2.err !== 1'b1 || bus2.err_code !== 2'd3 || bus2.count !== 3'd4)
                    $display("FAIL ovf_drop got we=%0b err=%0b code=%0d count=%0d want 0/1/3/4", bus2.imem_we, bus2.err, bus2.err_code, bus2.count);
                else n_pass++;
            end
        end
        bus2.in_valid = 0;
        bus2.in_last  = 0;
        tick;
        n_total++; if (bus2.done !== 1'b1 || bus2.imem_we !== 1'b0) $display("FAIL ovf_done got done=%0b we=%0b want 1/0", bus2.done, bus2.imem_we); else n_pass++;
    endtask

    task automatic test_reset_mid;
        start_session;
        set_b(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 1'b0);
        tick;
        bus.in_valid = 0;
        reset = 1;
        #1;
        n_total++; if (bus.imem_we !== 1'b0 || bus.imem_wdata !== 32'd0 || bus.count !== 11'd0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0)
            $display("FAIL reset_mid got we=%0b data=%08h count=%0d busy=%0b ready=%0b want all 0",
                     bus.imem_we, bus.imem_wdata, bus.count, bus.busy, bus.in_ready);
        else n_pass++;
        tick;
        reset = 0;
        tick;
        n_total++; if (bus.imem_we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0)
            $display("FAIL reset_mid_idle got we=%0b busy=%0b done=%0b err=%0b want 0/0/0/0", bus.imem_we, bus.busy, bus.done, bus.err);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset;
        test_i_type;
        test_back_to_back;
        test_bju;
        test_errors;
        test_start_ignored;
        test_overflow;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
